// File: rtl/digit_scan_driver.sv
// digit_scan_driver
// Time-multiplexed driver for NUM_DIGITS seven-segment digits on one shared
// segment bus. A prescaler (cnt) divides clk into digit slots of REFRESH_DIV
// cycles, and a digit index (idx) steps through the digits one slot at a time.
// The first GHOST_CYCLES of every slot keep all anodes off so that the previous
// digit's segments cannot ghost onto the next anode.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   i_en      display enable; when low the scan is parked at digit 0 and pins go inactive
//   i_digits  packed 4-bit codes, digit k at [4k+3:4k], digit 0 rightmost
//   i_blank   per-digit force-dark
//   i_dp      per-digit decimal point
//   seg_out   segments a..g on bits 0..6, at pin polarity
//   dp_out    decimal point, at pin polarity
//   an_out    one-hot anode select, at pin polarity
module digit_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GHOST_CYCLES   = 16,
  parameter int HEX_MODE       = 0,
  parameter int LZ_SUPPRESS    = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic HEX_EN = (HEX_MODE != 0);
  localparam logic LZ_EN  = (LZ_SUPPRESS != 0);

  // Pin-level inversion masks; the inactive pin level equals the mask.
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  // Active-high glyph for one code; hex letters only when HEX_EN is set.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0100111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      4'd10:   glyph = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'd11:   glyph = HEX_EN ? 7'b1111100 : 7'b0000000;
      4'd12:   glyph = HEX_EN ? 7'b0111001 : 7'b0000000;
      4'd13:   glyph = HEX_EN ? 7'b1011110 : 7'b0000000;
      4'd14:   glyph = HEX_EN ? 7'b1111001 : 7'b0000000;
      4'd15:   glyph = HEX_EN ? 7'b1110001 : 7'b0000000;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0]            code_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_zero_s;   // bit k: digits k..NUM_DIGITS-1 are all zero
  logic [3:0]            code_s;
  logic                  dark_s;
  logic [6:0]            seg_log_s;
  logic                  dp_log_s;
  logic [NUM_DIGITS-1:0] an_log_s;

  // Unpack digit codes and find which digits sit in the leading-zero run.
  always_comb begin : unpack_digits
    logic all_zero;
    all_zero  = 1'b1;
    lz_zero_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      code_arr[k] = i_digits[4*k +: 4];
    end
    // Walk down from the most significant digit, accumulating the zero run.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero & (code_arr[k] == 4'd0);
      lz_zero_s[k] = all_zero;
    end
  end

  // Next scan position and the pin-level outputs for the current position.
  always_comb begin
    code_s    = code_arr[idx_q];
    // Digit 0 is never leading-zero suppressed so an all-zero value still shows "0".
    dark_s    = i_blank[idx_q] | (LZ_EN & (idx_q != '0) & lz_zero_s[idx_q]);
    seg_log_s = dark_s ? 7'b0000000 : glyph(code_s);
    dp_log_s  = dark_s ? 1'b0 : i_dp[idx_q];
    an_log_s  = (cnt_q >= GHOST_END) ? (NUM_DIGITS'(1) << idx_q) : '0;

    if (!i_en) begin
      cnt_d = '0;
      idx_d = '0;
      seg_d = SEG_INV;
      dp_d  = DP_INV;
      an_d  = AN_INV;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
      seg_d = seg_log_s ^ SEG_INV;
      dp_d  = dp_log_s ^ DP_INV;
      an_d  = an_log_s ^ AN_INV;
    end
  end

  // Scan state and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_INV;
      dp_q  <= DP_INV;
      an_q  <= AN_INV;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver. Two instances share all inputs:
//   dut_a: HEX_MODE=1, LZ_SUPPRESS=1, active-high pins
//   dut_b: HEX_MODE=0, LZ_SUPPRESS=0, active-low segments and anodes
// The stimulus process predicts both instances' pins from a time-based
// reference (elapsed enabled cycles -> slot, position in slot, digit) and
// queues the prediction; a monitor pops one entry per edge and compares.
module tb_digit_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0100111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct packed {
    logic [11:0] a;   // {an, dp, seg}
    logic [11:0] b;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic [15:0]   digits;
  logic [ND-1:0] blank;
  logic [ND-1:0] dp;

  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b;
  logic [ND-1:0] an_a, an_b;

  exp_t        sb [$];
  int unsigned t;        // enabled cycles since the scan last restarted
  int          checks;
  int          errors;
  bit          done;

  digit_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .HEX_MODE(1),
    .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .reset(rst), .i_en(en), .i_digits(digits), .i_blank(blank),
    .i_dp(dp), .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a)
  );

  digit_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYCLES(GC), .HEX_MODE(0),
    .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .reset(rst), .i_en(en), .i_digits(digits), .i_blank(blank),
    .i_dp(dp), .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high {an, dp, seg} for position t with the current inputs.
  function automatic logic [11:0] model(input bit hex, input bit lz);
    int unsigned cnt, idx;
    logic [15:0] upper;
    logic [3:0]  code;
    bit          dark;
    logic [6:0]  sg;
    logic        d;
    logic [3:0]  an;
    cnt   = t % RD;
    idx   = (t / RD) % ND;
    upper = digits >> (4 * idx);
    code  = upper[3:0];
    dark  = blank[idx] || (lz && idx != 0 && upper == 16'h0000);
    sg    = (code < 4'd10 || hex) ? GLYPH[code] : 7'h00;
    if (dark) sg = 7'h00;
    d     = dark ? 1'b0 : dp[idx];
    an    = (cnt >= GC) ? (4'b0001 << idx) : 4'b0000;
    return {an, d, sg};
  endfunction

  // Predict the outputs produced by the coming edge, then advance one cycle.
  task automatic step();
    exp_t e;
    if (rst || !en) begin
      e.a = 12'h000;
      e.b = 12'hFFF;
      t   = 0;
    end else begin
      e.a = model(1'b1, 1'b1);
      e.b = model(1'b0, 1'b0) ^ 12'hFFF;
      t++;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: one output set per edge, compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_seg", seg_a, e.a[6:0]);
        chk("a_dp", {6'd0, dp_a}, {6'd0, e.a[7]});
        chk("a_an", {3'd0, an_a}, {3'd0, e.a[11:8]});
        chk("b_seg", seg_b, e.b[6:0]);
        chk("b_dp", {6'd0, dp_b}, {6'd0, e.b[7]});
        chk("b_an", {3'd0, an_b}, {3'd0, e.b[11:8]});
      end
    end
  end

  initial begin
    logic [15:0] masks [4];
    masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF; masks[3] = 16'h000F;
    checks = 0; errors = 0; t = 0; done = 1'b0;
    rst = 1'b1; en = 1'b0; digits = 16'h0000; blank = '0; dp = '0;
    run(2);
    rst = 1'b0; en = 1'b1; digits = 16'h1234;
    run(20);
    digits = 16'h00AF;      run(16);
    digits = 16'h0005;      run(16);
    digits = 16'h0000;      run(16);
    digits = 16'h0105;      run(16);
    digits = 16'h8888; blank = 4'b0010; dp = 4'b0110; run(16);
    blank = '0; dp = '0;
    run(2);
    en = 1'b0;              run(3);    // drop mid-slot
    en = 1'b1;              run(10);
    rst = 1'b1;             run(1);    // reset mid-scan
    rst = 1'b0;             run(10);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) digits = 16'($urandom) & masks[$urandom_range(3)];
      if ($urandom_range(7) == 0) blank = 4'($urandom) & 4'($urandom);
      if ($urandom_range(5) == 0) dp = 4'($urandom);
      en  = ($urandom_range(29) != 0);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0; en = 1'b1;
    run(2);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
